// File: rtl/unidade_controle.sv
// Control unit for the 8-bit accumulator processor. This is a Moore FSM that
// sequences fetch, decode and the per-opcode execute states for caminho_dados.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [7:0] CCR_Result,
    output logic [2:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic [2:0] alu_sel,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       PR_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       C_Load,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       CCR_Load,
    output logic       Memory_Load,
    output logic       halted
);

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_INCPR   = 8'h01;
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDC_IMM = 8'h8A;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] B1_PC = 3'b000;
    localparam logic [2:0] B1_A  = 3'b001;
    localparam logic [2:0] B1_B  = 3'b010;

    localparam logic [1:0] B2_BUS1 = 2'b00;
    localparam logic [1:0] B2_MEM  = 2'b10;
    localparam logic [1:0] B2_ALU  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [4:0] {
        S_RESET,
        S_F0,
        S_F1,
        S_F2,
        S_DEC,
        S_INCPR,
        S_LDAI_0,
        S_LDAI_1,
        S_LDAI_2,
        S_LDBI_0,
        S_LDBI_1,
        S_LDBI_2,
        S_LDCI_0,
        S_LDCI_1,
        S_LDCI_2,
        S_LDAD_0,
        S_LDAD_1,
        S_LDAD_2,
        S_LDAD_3,
        S_LDAD_4,
        S_STA_0,
        S_STA_1,
        S_STA_2,
        S_STA_3,
        S_ADD,
        S_SUB,
        S_BRA_0,
        S_BRA_1,
        S_BRA_2,
        S_BEQ_SKIP,
        S_HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic zero_flag;
    logic unused_flags;

    // Only Z steers a branch; N, V and C are carried for the datapath's benefit.
    assign zero_flag    = CCR_Result[2];
    assign unused_flags = ^{CCR_Result[7:3], CCR_Result[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_F0;
            S_F0:       state_d = S_F1;
            S_F1:       state_d = S_F2;
            S_F2:       state_d = S_DEC;
            S_DEC: begin
                case (IR)
                    OP_NOP:     state_d = S_F0;
                    OP_INCPR:   state_d = S_INCPR;
                    OP_LDA_IMM: state_d = S_LDAI_0;
                    OP_LDB_IMM: state_d = S_LDBI_0;
                    OP_LDC_IMM: state_d = S_LDCI_0;
                    OP_LDA_DIR: state_d = S_LDAD_0;
                    OP_STA_DIR: state_d = S_STA_0;
                    OP_ADD_AB:  state_d = S_ADD;
                    OP_SUB_AB:  state_d = S_SUB;
                    OP_BRA:     state_d = S_BRA_0;
                    OP_BEQ:     state_d = zero_flag ? S_BRA_0 : S_BEQ_SKIP;
                    OP_HALT:    state_d = S_HALT;
                    default:    state_d = S_F0;
                endcase
            end
            S_INCPR:    state_d = S_F0;
            S_LDAI_0:   state_d = S_LDAI_1;
            S_LDAI_1:   state_d = S_LDAI_2;
            S_LDAI_2:   state_d = S_F0;
            S_LDBI_0:   state_d = S_LDBI_1;
            S_LDBI_1:   state_d = S_LDBI_2;
            S_LDBI_2:   state_d = S_F0;
            S_LDCI_0:   state_d = S_LDCI_1;
            S_LDCI_1:   state_d = S_LDCI_2;
            S_LDCI_2:   state_d = S_F0;
            S_LDAD_0:   state_d = S_LDAD_1;
            S_LDAD_1:   state_d = S_LDAD_2;
            S_LDAD_2:   state_d = S_LDAD_3;
            S_LDAD_3:   state_d = S_LDAD_4;
            S_LDAD_4:   state_d = S_F0;
            S_STA_0:    state_d = S_STA_1;
            S_STA_1:    state_d = S_STA_2;
            S_STA_2:    state_d = S_STA_3;
            S_STA_3:    state_d = S_F0;
            S_ADD:      state_d = S_F0;
            S_SUB:      state_d = S_F0;
            S_BRA_0:    state_d = S_BRA_1;
            S_BRA_1:    state_d = S_BRA_2;
            S_BRA_2:    state_d = S_F0;
            S_BEQ_SKIP: state_d = S_F0;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_RESET;
        endcase
    end

    always_comb begin
        Bus1_Sel    = B1_PC;
        Bus2_Sel    = B2_BUS1;
        alu_sel     = ALU_ADD;
        PC_Load     = 1'b0;
        PC_Inc      = 1'b0;
        PR_Inc      = 1'b0;
        A_Load      = 1'b0;
        B_Load      = 1'b0;
        C_Load      = 1'b0;
        IR_Load     = 1'b0;
        MAR_Load    = 1'b0;
        CCR_Load    = 1'b0;
        Memory_Load = 1'b0;
        halted      = 1'b0;
        case (state_q)
            // MAR <- PC, shared by the opcode fetch and every operand fetch
            S_F0, S_LDAI_0, S_LDBI_0, S_LDCI_0, S_LDAD_0, S_STA_0, S_BRA_0: begin
                MAR_Load = 1'b1;
                Bus1_Sel = B1_PC;
                Bus2_Sel = B2_BUS1;
            end
            S_F1, S_LDAI_1, S_LDBI_1, S_LDCI_1, S_LDAD_1, S_STA_1, S_BRA_1,
            S_BEQ_SKIP: begin
                PC_Inc = 1'b1;
            end
            S_F2: begin
                IR_Load  = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            S_INCPR: begin
                PR_Inc = 1'b1;
            end
            S_LDAI_2, S_LDAD_4: begin
                A_Load   = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            S_LDBI_2: begin
                B_Load   = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            S_LDCI_2: begin
                C_Load   = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            // The operand byte is itself an address: reload MAR from memory
            S_LDAD_2, S_STA_2: begin
                MAR_Load = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            S_STA_3: begin
                Memory_Load = 1'b1;
                Bus1_Sel    = B1_A;
            end
            S_ADD, S_SUB: begin
                Bus1_Sel = B1_B;
                alu_sel  = (state_q == S_SUB) ? ALU_SUB : ALU_ADD;
                Bus2_Sel = B2_ALU;
                A_Load   = 1'b1;
                CCR_Load = 1'b1;
            end
            S_BRA_2: begin
                PC_Load  = 1'b1;
                Bus2_Sel = B2_MEM;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: a cycle-level datapath/memory model closes the loop,
// and an instruction-level ISA model predicts every fetch, halt and memory write.
module tb_unidade_controle;

    logic       clock;
    logic       reset;
    logic [7:0] IR;
    logic [7:0] CCR_Result;
    logic [2:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic [2:0] alu_sel;
    logic       PC_Load, PC_Inc, PR_Inc, A_Load, B_Load, C_Load;
    logic       IR_Load, MAR_Load, CCR_Load, Memory_Load, halted;

    unidade_controle dut (
        .clock(clock), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .alu_sel(alu_sel),
        .PC_Load(PC_Load), .PC_Inc(PC_Inc), .PR_Inc(PR_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .C_Load(C_Load),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .CCR_Load(CCR_Load),
        .Memory_Load(Memory_Load), .halted(halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        halt;
        logic        len_chk;
        logic [15:0] len;
        logic [7:0]  op;
        logic [7:0]  pc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  ccr;
        logic [7:0]  pr;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] wr_q[$];
    logic        exp_halt;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [7:0] img [256];
    logic [7:0] mem [256];
    logic [7:0] pc_q, a_q, b_q, c_q, pr_q, ir_q, mar_q, ccr_q, mem_rd_q;
    logic [7:0] bus1, bus2, alu_res;
    logic [3:0] alu_flags;
    logic [31:0] outs_w;

    assign IR         = ir_q;
    assign CCR_Result = ccr_q;
    assign outs_w = {13'd0, Bus1_Sel, Bus2_Sel, alu_sel, PC_Load, PC_Inc, PR_Inc,
                     A_Load, B_Load, C_Load, IR_Load, MAR_Load, CCR_Load,
                     Memory_Load, halted};

    // Flags are {N,Z,V,C}; C is carry for ADD and borrow for SUB.
    function automatic logic [11:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                          input logic sub);
        logic [8:0] s;
        logic [7:0] r;
        logic       v;
        s = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r = s[7:0];
        v = sub ? ((x[7] != y[7]) && (r[7] != x[7])) : ((x[7] == y[7]) && (r[7] != x[7]));
        return {r[7], (r == 8'h00), v, s[8], r};
    endfunction

    always_comb begin
        case (Bus1_Sel)
            3'b000:  bus1 = pc_q;
            3'b001:  bus1 = a_q;
            3'b010:  bus1 = b_q;
            3'b011:  bus1 = c_q;
            3'b100:  bus1 = pr_q;
            3'b101:  bus1 = ir_q;
            default: bus1 = 8'h00;
        endcase
    end

    always_comb begin
        {alu_flags, alu_res} = 12'h000;
        if (alu_sel == 3'b000)      {alu_flags, alu_res} = alu_f(a_q, bus1, 1'b0);
        else if (alu_sel == 3'b001) {alu_flags, alu_res} = alu_f(a_q, bus1, 1'b1);
    end

    always_comb begin
        case (Bus2_Sel)
            2'b00:   bus2 = bus1;
            2'b01:   bus2 = 8'h01;
            2'b10:   bus2 = mem_rd_q;
            default: bus2 = alu_res;
        endcase
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= 8'h00; a_q <= 8'h00; b_q <= 8'h00; c_q <= 8'h00;
            pr_q <= 8'h00; ir_q <= 8'h00; mar_q <= 8'h00; ccr_q <= 8'h00;
        end else begin
            if (PC_Load)     pc_q <= pc_q + bus2;
            else if (PC_Inc) pc_q <= pc_q + 8'd1;
            if (PR_Inc)   pr_q  <= pr_q + 8'd1;
            if (A_Load)   a_q   <= bus2;
            if (B_Load)   b_q   <= bus2;
            if (C_Load)   c_q   <= bus2;
            if (IR_Load)  ir_q  <= bus2;
            if (MAR_Load) mar_q <= bus2;
            if (CCR_Load) ccr_q <= {4'h0, alu_flags};
        end
    end

    // Registered read: data appears two edges after MAR is loaded.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (Memory_Load) begin
            mem[mar_q] <= bus1;
        end
        mem_rd_q <= mem[mar_q];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction-level model: one iteration per instruction, fixed cycle table.
    task automatic build_expect(input int max_ev);
        logic [7:0]  m [256];
        logic [7:0]  pc, a, b, c, ccr, pr, op, opr;
        logic [11:0] r;
        logic [15:0] len;
        logic        chk;
        ev_t         e;
        m = img;
        pc = 8'h00; a = 8'h00; b = 8'h00; c = 8'h00; ccr = 8'h00; pr = 8'h00;
        len = 16'd0; chk = 1'b0; exp_halt = 1'b0;
        for (int ev = 0; ev < max_ev; ev++) begin
            op = m[pc];
            pc = pc + 8'd1;
            e.halt = 1'b0; e.len_chk = chk; e.len = len; e.op = op; e.pc = pc;
            e.a = a; e.b = b; e.c = c; e.ccr = ccr; e.pr = pr;
            exp_q.push_back(e);
            if (ev == max_ev - 1) break;
            chk = 1'b1;
            len = 16'd4;
            case (op)
                8'h01: begin pr = pr + 8'd1; len = 16'd5; end
                8'h86, 8'h88, 8'h8A: begin
                    opr = m[pc]; pc = pc + 8'd1; len = 16'd7;
                    if (op == 8'h86) a = opr;
                    else if (op == 8'h88) b = opr;
                    else c = opr;
                end
                8'h87: begin a = m[m[pc]]; pc = pc + 8'd1; len = 16'd9; end
                8'h96: begin
                    opr = m[pc]; m[opr] = a; wr_q.push_back({opr, a});
                    pc = pc + 8'd1; len = 16'd8;
                end
                8'h42, 8'h43: begin
                    r = alu_f(a, b, (op == 8'h43)); ccr = {4'h0, r[11:8]}; a = r[7:0];
                    len = 16'd5;
                end
                8'h20: begin opr = m[pc]; pc = pc + 8'd1; pc = pc + opr; len = 16'd7; end
                8'h23: begin
                    if (ccr[2]) begin opr = m[pc]; pc = pc + 8'd1; pc = pc + opr; len = 16'd7; end
                    else begin pc = pc + 8'd1; len = 16'd5; end
                end
                8'hFF: begin
                    e.halt = 1'b1; e.len_chk = 1'b1; e.len = 16'd2;
                    exp_q.push_back(e);
                    exp_halt = 1'b1;
                    break;
                end
                default: len = 16'd4;
            endcase
        end
    endtask

    initial begin : monitor
        int   cyc;
        logic halted_prev;
        logic is_fetch;
        ev_t  act, e;
        logic [15:0] w;
        cyc = 0;
        halted_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                cyc = 0;
                halted_prev = 1'b0;
            end else begin
                cyc++;
                n_cmp++;
                if ((PC_Load && PC_Inc) || ($countones({A_Load, B_Load, C_Load}) > 1)) begin
                    n_fail++;
                    $display("FAIL strobe_exclusive: got pc_ld/inc=%b%b abc=%b%b%b, expected at most one each",
                             PC_Load, PC_Inc, A_Load, B_Load, C_Load);
                end
                is_fetch = IR_Load;
                if (IR_Load || (halted && !halted_prev)) begin
                    act.halt = !is_fetch; act.len_chk = 1'b1; act.len = 16'(cyc);
                    act.op = is_fetch ? bus2 : ir_q; act.pc = pc_q; act.a = a_q; act.b = b_q;
                    act.c = c_q; act.ccr = ccr_q; act.pr = pr_q;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got halt=%0d op=%h pc=%h, expected no event",
                                 act.halt, act.op, act.pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.len_chk) begin act.len_chk = 1'b0; act.len = e.len; end
                        if (act !== e) begin
                            n_fail++;
                            $display("FAIL %s: got halt=%0d op=%h pc=%h a=%h b=%h c=%h ccr=%h pr=%h len=%0d, expected halt=%0d op=%h pc=%h a=%h b=%h c=%h ccr=%h pr=%h len=%0d",
                                     is_fetch ? "fetch" : "halt", act.halt, act.op, act.pc, act.a, act.b,
                                     act.c, act.ccr, act.pr, act.len, e.halt, e.op, e.pc, e.a, e.b, e.c,
                                     e.ccr, e.pr, e.len);
                        end
                    end
                    cyc = 0;
                end
                if (Memory_Load) begin
                    n_cmp++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mar_q, bus1);
                    end else begin
                        w = wr_q.pop_front();
                        if ({Bus1_Sel, mar_q, bus1} !== {3'b001, w}) begin
                            n_fail++;
                            $display("FAIL mem_write: got sel=%b addr=%h data=%h, expected sel=001 addr=%h data=%h",
                                     Bus1_Sel, mar_q, bus1, w[15:8], w[7:0]);
                        end
                    end
                end
                halted_prev = halted;
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic start_prog(input int max_ev);
        reset = 1'b0;
        exp_q.delete();
        wr_q.delete();
        build_expect(max_ev);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_before_budget", {30'd0, (exp_q.size() == 0), (wr_q.size() == 0)}, 32'd3);
        if (exp_halt) begin
            repeat (6) @(posedge clock);
            #1;
            check("halt_sticky", {31'd0, halted}, 32'd1);
        end
    endtask

    task automatic load_bytes(input logic [7:0] b [], input logic [7:0] base);
        clear_img();
        for (int i = 0; i < b.size(); i++) img[8'(base + 8'(i))] = b[i];
    endtask

    task automatic find_lda_dir_mar(output logic found);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (MAR_Load && (Bus2_Sel == 2'b10)) found = 1'b1;
        end
    endtask

    task automatic gen_random();
        logic [7:0] ops [16];
        logic [7:0] op;
        int p;
        ops = '{8'h00, 8'h01, 8'h86, 8'h88, 8'h8A, 8'h87, 8'h96, 8'h42,
                8'h43, 8'h20, 8'h23, 8'h7E, 8'h42, 8'h43, 8'h23, 8'hFF};
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        p = 0;
        while (p < 120) begin
            op = ops[$urandom_range(0, 15)];
            img[p] = op;
            p++;
            if (op == 8'h87 || op == 8'h96)      img[p] = 8'(8'h80 + 8'($urandom_range(0, 127)));
            else if (op == 8'h20 || op == 8'h23) img[p] = 8'($urandom_range(0, 6));
            else if (op[7])                      img[p] = 8'($urandom);
            if (op[7] || op == 8'h20 || op == 8'h23) p++;
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] pat;
        logic       found;
        reset = 1'b1;
        clear_img();
        #2 reset = 1'b0;
        #1 check("reset_outputs", outs_w, 32'd0);

        // NOP stream with explicit strobe pattern
        clear_img();
        start_prog(8);
        @(negedge clock);
        check("reset_cycle_idle", outs_w, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            pat = ((k % 4) == 3) ? 8'h00 : (8'h04 >> (k % 4));
            check("nop_pattern", {29'd0, MAR_Load, PC_Inc, IR_Load}, {24'd0, pat});
        end
        wait_done(100);

        load_bytes('{8'h86, 8'h05, 8'h88, 8'h03, 8'h42, 8'hFF}, 8'h00);
        start_prog(20);
        wait_done(60);

        load_bytes('{8'h86, 8'h03, 8'h88, 8'h03, 8'h43, 8'h23, 8'h02, 8'h01, 8'h01, 8'hFF}, 8'h00);
        start_prog(20);
        wait_done(80);

        load_bytes('{8'h86, 8'h03, 8'h88, 8'h01, 8'h43, 8'h23, 8'h02, 8'hFF}, 8'h00);
        start_prog(20);
        wait_done(80);

        load_bytes('{8'h86, 8'hA5, 8'h96, 8'h40, 8'h86, 8'h00, 8'h87, 8'h40, 8'hFF}, 8'h00);
        start_prog(20);
        wait_done(80);

        load_bytes('{8'hFE, 8'h20, 8'hFC}, 8'h00);
        img[8'hFF] = 8'h20;
        start_prog(8);
        wait_done(100);

        load_bytes('{8'h7E, 8'h7E, 8'h7E, 8'hFF}, 8'h00);
        start_prog(10);
        wait_done(60);

        // Reset while strobes are active, then reset in the LDA_DIR wait state
        load_bytes('{8'h87, 8'h40, 8'hFF}, 8'h00);
        img[8'h40] = 8'h33;
        start_prog(20);
        find_lda_dir_mar(found);
        check("abort_find_strobe", {31'd0, found}, 32'd1);
        #1 reset = 1'b0;
        #1 check("abort_outputs_strobe", outs_w, 32'd0);
        start_prog(20);
        @(negedge clock);
        check("release_cycle1", {31'd0, MAR_Load}, 32'd0);
        @(negedge clock);
        check("release_cycle2", {28'd0, MAR_Load, Bus1_Sel}, 32'h8);
        find_lda_dir_mar(found);
        check("abort_find_wait", {31'd0, found}, 32'd1);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 check("abort_outputs_wait", outs_w, 32'd0);
        start_prog(20);
        wait_done(80);

        for (int t = 0; t < 40; t++) begin
            gen_random();
            start_prog(25);
            wait_done(25 * 10 + 20);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Moore-style control FSM for the 8-bit processor, sitting directly upstream of the `caminho_dados` datapath. It sequences fetch, decode and execute for a small accumulator ISA. It observes `IR` and `CCR_Result` from the datapath and drives every datapath select, load and increment strobe, plus the ALU operation select. One instruction executes at a time, with fixed per-opcode cycle counts.

## Interface
- No parameters.
- `clock` in 1: system clock; all state changes occur on its rising edge.
- `reset` in 1: asynchronous, active-low; forces state `S_RESET`.
- `IR` in 8: current instruction byte from the datapath.
- `CCR_Result` in 8: flags from the datapath; bit3=N, bit2=Z, bit1=V, bit0=C.
- `Bus1_Sel` out 3: 000=PC, 001=A, 010=B, 011=C, 100=PR, 101=IR.
- `Bus2_Sel` out 2: 00=Bus1, 01=const 1, 10=from_memory, 11=ALU_Result.
- `alu_sel` out 3: 000=ADD (A+Bus1), 001=SUB (A−Bus1); other codes are reserved.
- `PC_Load`, `PC_Inc`, `PR_Inc`, `A_Load`, `B_Load`, `C_Load`, `IR_Load`, `MAR_Load`, `CCR_Load`, `Memory_Load` out 1 each: datapath strobes.
- `halted` out 1: high while the FSM is in `S_HALT`.

## Operation
- Outputs are decoded from the current state only.
  - Defaults: all strobes 0, `Bus1_Sel`=000, `Bus2_Sel`=00, `alu_sel`=000.
  - States below list only the non-default outputs.
- Memory contract: `from_memory` is valid for the MAR value loaded two edges earlier, i.e. one wait state after the `MAR_Load` cycle.
- **S_RESET**: all outputs at default. Next state is S_F0.
- **Fetch**
  - S_F0: `MAR_Load`, with `Bus1_Sel`=PC and `Bus2_Sel`=Bus1.
  - S_F1: `PC_Inc`.
  - S_F2: `IR_Load`, with `Bus2_Sel`=from_memory.
  - S_DEC: no strobes. The next state is chosen from `IR`.
- **Operand fetch sequence (OPF)**: MAR←PC, then `PC_Inc`, then the operand is available on `from_memory`.
- **Opcodes** (each execute sequence ends by returning to S_F0):
  - 0x00 NOP: back to S_F0.
  - 0x01 INCPR: one state with `PR_Inc`.
  - 0x86 LDA_IMM: OPF, then `A_Load` with `Bus2`=from_memory.
  - 0x88 LDB_IMM: same as LDA_IMM, but with `B_Load`.
  - 0x8A LDC_IMM: same as LDA_IMM, but with `C_Load`.
  - 0x87 LDA_DIR: OPF; then MAR←from_memory; then one wait state; then `A_Load` with `Bus2`=from_memory.
  - 0x96 STA_DIR: OPF; then MAR←from_memory; then `Memory_Load` with `Bus1_Sel`=A.
  - 0x42 ADD_AB: one state with `Bus1_Sel`=B, `alu_sel`=000, `Bus2_Sel`=ALU_Result, `A_Load` and `CCR_Load`.
  - 0x43 SUB_AB: same as ADD_AB, but with `alu_sel`=001.
  - 0x20 BRA: OPF, then `PC_Load` with `Bus2`=from_memory.
    - The datapath computes PC←PC+offset, where PC already points past the offset byte; the offset wraps mod 256.
  - 0x23 BEQ: the branch decision is taken in S_DEC from `CCR_Result[2]`.
    - Z=1: executes the BRA sequence.
    - Z=0: one state with `PC_Inc` to skip the operand.
  - 0xFF HALT: enters S_HALT, which has no strobes and `halted`=1. The FSM stays there until reset.
  - Any other opcode: treated as NOP.
- At most one of `PC_Load`/`PC_Inc` is asserted in any state.
- No state asserts two of `A_Load`/`B_Load`/`C_Load`.

## Timing
- Reset value: state is S_RESET and every output is 0, including `halted`=0.
  - This holds asynchronously on the falling edge of `reset`.
  - The FSM leaves S_RESET on the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction aborts the instruction immediately; no partial strobe survives the reset.
- Cycle counts, from S_F0 entry to the next S_F0 entry:
  - NOP and unknown opcodes: 4.
  - INCPR, ADD_AB, SUB_AB: 5.
  - LDA_IMM, LDB_IMM, LDC_IMM: 7.
  - STA_DIR: 8.
  - LDA_DIR: 9.
  - BRA and BEQ taken: 7.
  - BEQ not taken: 5.
- HALT takes 4 cycles to reach S_HALT.
- In S_DEC, `IR` is sampled on the edge that leaves S_DEC. This is the `IR` loaded on the edge ending S_F2.
- For BEQ, `CCR_Result` is sampled on the same edge as `IR`. A `CCR_Load` issued by the immediately preceding instruction is therefore visible.

## Test plan
- Reset release with a NOP stream:
  - Required strobe pattern: `MAR_Load`, `PC_Inc`, `IR_Load`, then idle, repeating every 4 cycles.
  - PC must increment once per fetch.
- Sequence LDA_IMM 0x05, LDB_IMM 0x03, ADD_AB, HALT:
  - A=0x08 and CCR=0x00.
  - `halted` high after 7+7+5+4=23 cycles from S_F0.
- Sequence LDA_IMM 0x03, LDB_IMM 0x03, SUB_AB, BEQ +2 (Z=1):
  - BEQ is taken and PC advances by 2 extra.
  - Repeat with B=0x01: BEQ is not taken, lasts exactly 5 cycles, and PC skips only the operand byte.
- Sequence LDA_IMM 0xA5, STA_DIR 0x40, LDA_IMM 0x00, LDA_DIR 0x40:
  - `Memory_Load` pulses once, with `Bus1_Sel`=001 while MAR=0x40.
  - Final A=0xA5.
- BRA with offset 0xFE, from a PC where it forms a tight loop:
  - PC wraps correctly mod 256.
  - The loop repeats every 7 cycles.
- Reset pulsed low during the LDA_DIR wait state:
  - All outputs go to 0 immediately.
  - After release, the first `MAR_Load` occurs on the second cycle.
- Unknown opcode 0x7E:
  - Behaves as NOP, lasting 4 cycles with no register strobes.
